// File: rtl/fetch_unit_param_pkg.sv
// Shared constants and helpers for the parametrised fetch stage.
package fetch_unit_param_pkg;

  localparam int INST_WIDTH = 32;
  localparam logic [INST_WIDTH-1:0] LNOP_ENCODING = 32'h0020_0000;

  typedef logic [INST_WIDTH-1:0] inst_t;

  // Index width that stays legal (>= 1 bit) for single-entry dimensions.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_unit_param_queue.sv
// Circular FIFO holding fetched bundles; flush wins over push/pop.
module fetch_queue
  import fetch_unit_param_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = index_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign pop_ok = pop && !empty;
  assign head   = storage[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop_ok)      count <= count + CW'(1);
      else if (pop_ok && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) storage[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit_param.sv
// Fetch stage: block-aligned imem requests, epoch-tagged responses, buffered
// hand-off to decode with LNOP masking of slots before a redirect target.
module fetch_unit_param
  import fetch_unit_param_pkg::*;
#(
  parameter int                  ISSUE_WIDTH = 2,
  parameter int                  IMEM_BYTES  = 2048,
  parameter int                  PC_WIDTH    = 32,
  parameter int                  FIFO_DEPTH  = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            redirect_valid,
  input  logic [PC_WIDTH-1:0]             redirect_pc,
  output logic                            imem_req,
  output logic [$clog2(IMEM_BYTES)-1:0]   imem_addr,
  input  logic [INST_WIDTH*ISSUE_WIDTH-1:0] imem_rdata,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PC_WIDTH-1:0]             out_pc,
  output logic [INST_WIDTH*ISSUE_WIDTH-1:0] out_inst,
  output logic [ISSUE_WIDTH-1:0]          out_slot_valid
);

  localparam int FB = 4 * ISSUE_WIDTH;
  localparam int AW = $clog2(IMEM_BYTES);
  localparam int SW = index_width(ISSUE_WIDTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(FB - 1);
  localparam logic [AW-1:0]       FB_STEP    = AW'(FB);

  typedef struct packed {
    logic [PC_WIDTH-1:0]           pc;
    inst_t [ISSUE_WIDTH-1:0]       inst;
    logic [ISSUE_WIDTH-1:0]        mask;
  } fetch_bundle_t;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic                epoch;
  logic [SW-1:0]       pending_start;
  logic [SW-1:0]       redirect_start;
  logic [AW-1:0]       next_addr;
  logic                inflight;
  logic                tag_epoch;
  logic [SW-1:0]       tag_start;
  logic [PC_WIDTH-1:0] tag_pc;
  logic [CW-1:0]       q_count;
  logic                q_full;
  logic                q_empty;
  logic                push;
  logic                pop;
  fetch_bundle_t       resp_bundle;
  fetch_bundle_t       head;

  assign redirect_start = SW'((redirect_pc >> 2) & PC_WIDTH'(ISSUE_WIDTH - 1));
  assign next_addr      = fetch_pc[AW-1:0] + FB_STEP;

  // Counting the in-flight slot guarantees every response has room in the queue.
  assign imem_req  = reset && !redirect_valid &&
                     ((OW'(q_count) + OW'(inflight)) < OW'(FIFO_DEPTH));
  assign imem_addr = reset ? fetch_pc[AW-1:0] : '0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc      <= RESET_PC & ALIGN_MASK;
      epoch         <= 1'b0;
      pending_start <= '0;
      inflight      <= 1'b0;
      tag_epoch     <= 1'b0;
      tag_start     <= '0;
      tag_pc        <= '0;
    end else begin
      inflight <= imem_req;
      if (redirect_valid) begin
        epoch         <= ~epoch;
        fetch_pc      <= redirect_pc & ALIGN_MASK;
        pending_start <= redirect_start;
      end else if (imem_req) begin
        fetch_pc      <= PC_WIDTH'(next_addr);
        tag_pc        <= fetch_pc;
        tag_epoch     <= epoch;
        tag_start     <= pending_start;
        pending_start <= '0;
      end
    end
  end

  // Slot s lives in packed element ISSUE_WIDTH-1-s so slot 0 lands in the MSBs.
  always_comb begin
    resp_bundle    = '0;
    resp_bundle.pc = tag_pc;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      resp_bundle.mask[j] = (ISSUE_WIDTH - 1 - j) >= int'(tag_start);
      resp_bundle.inst[j] = resp_bundle.mask[j] ? imem_rdata[INST_WIDTH*j +: INST_WIDTH]
                                                : LNOP_ENCODING;
    end
  end

  assign push      = inflight && (tag_epoch == epoch) && !redirect_valid && (!q_full || pop);
  assign out_valid = !q_empty && !redirect_valid;
  assign pop       = out_valid && out_ready;

  fetch_queue #(
    .WIDTH ($bits(fetch_bundle_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fetch_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (resp_bundle),
    .pop       (pop),
    .head      (head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign out_pc         = q_empty ? '0 : head.pc;
  assign out_inst       = q_empty ? '0 : head.inst;
  assign out_slot_valid = q_empty ? '0 : head.mask;

endmodule

// File: tb/tb_fetch_unit_param.sv
// Bench for fetch_unit_param: directed scenarios plus randomized redirect/stall
// traffic checked against a bundle-stream reference model.
module tb_fetch_unit_param;

  localparam int IW    = 2;
  localparam int IMEM  = 2048;
  localparam int PCW   = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;
  localparam int FB    = 4 * IW;
  localparam int AW    = $clog2(IMEM);
  localparam int WORDS = IMEM / 4;
  localparam logic [31:0] LNOP = 32'h0020_0000;

  logic              clock = 1'b0;
  logic              reset;
  logic              redirect_valid;
  logic [PCW-1:0]    redirect_pc;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic [32*IW-1:0]  imem_rdata = '0;
  logic              out_valid;
  logic              out_ready;
  logic [PCW-1:0]    out_pc;
  logic [32*IW-1:0]  out_inst;
  logic [IW-1:0]     out_slot_valid;

  int n_checks = 0;
  int n_errors = 0;
  int accepted = 0;
  logic [31:0] mem_word [WORDS];
  logic [31:0] exp_pc;
  int          exp_start;

  fetch_unit_param #(
    .ISSUE_WIDTH (IW),
    .IMEM_BYTES  (IMEM),
    .PC_WIDTH    (PCW),
    .FIFO_DEPTH  (DEPTH),
    .RESET_PC    (RST_PC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_slot_valid (out_slot_valid)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] block_of(input logic [31:0] pc);
    return pc & ~(FB - 1);
  endfunction

  function automatic int start_of(input logic [31:0] pc);
    return int'((pc >> 2) & (IW - 1));
  endfunction

  function automatic logic [IW-1:0] model_mask(input int start);
    model_mask = '0;
    for (int i = 0; i < IW; i++) model_mask[IW-1-i] = (i >= start);
  endfunction

  function automatic logic [32*IW-1:0] model_inst(input logic [31:0] pc, input int start);
    model_inst = '0;
    for (int i = 0; i < IW; i++)
      model_inst[32*(IW-i)-1 -: 32] = (i >= start) ? mem_word[((pc >> 2) + i) % WORDS] : LNOP;
  endfunction

  // Synchronous 1-cycle memory; garbage on idle cycles.
  always @(posedge clock) begin
    if (imem_req) begin
      for (int i = 0; i < IW; i++)
        imem_rdata[32*(IW-i)-1 -: 32] <= mem_word[(int'(imem_addr) >> 2) + i];
    end else begin
      imem_rdata <= {IW{$urandom()}};
    end
  end

  // Stream model: decode must see consecutive blocks from reset PC or the last redirect.
  always @(negedge clock) begin
    if (!reset) begin
      check_val("valid_in_reset", out_valid, 1'b0);
      exp_pc    = block_of(RST_PC);
      exp_start = 0;
    end else if (redirect_valid) begin
      check_val("valid_in_redirect", out_valid, 1'b0);
      exp_pc    = block_of(redirect_pc);
      exp_start = start_of(redirect_pc);
    end else if (out_valid && out_ready) begin
      check_val("stream_pc", out_pc, exp_pc);
      check_val("stream_mask", out_slot_valid, model_mask(exp_start));
      check_val("stream_inst", out_inst, model_inst(exp_pc, exp_start));
      accepted++;
      exp_pc    = (exp_pc + FB) % IMEM;
      exp_start = 0;
    end
  end

  task automatic redirect_and_land(input logic [31:0] pc);
    logic [31:0] blk;
    blk = block_of(pc);
    @(posedge clock); #2;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clock);
    check_val("req_suppressed", imem_req, 1'b0);
    @(posedge clock); #2;
    redirect_valid = 1'b0;
    @(negedge clock);
    check_val("redir_req", imem_req, 1'b1);
    check_val("redir_addr0", imem_addr, blk[AW-1:0]);
    check_val("redir_valid_n1", out_valid, 1'b0);
    @(negedge clock);
    check_val("redir_addr1", imem_addr, AW'((blk + FB) % IMEM));
    check_val("redir_valid_n2", out_valid, 1'b0);
    @(negedge clock);
    check_val("redir_valid_n3", out_valid, 1'b1);
    check_val("redir_pc", out_pc, blk);
    check_val("redir_mask", out_slot_valid, model_mask(start_of(pc)));
    check_val("redir_inst", out_inst, model_inst(blk, start_of(pc)));
  endtask

  initial begin
    int nreq;
    int head_bad;
    int acc0;
    for (int w = 0; w < WORDS; w++) mem_word[w] = 32'h100 + w;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b1;

    repeat (3) @(negedge clock);
    check_val("rst_req", imem_req, 1'b0);
    check_val("rst_addr", imem_addr, '0);
    check_val("rst_out_pc", out_pc, '0);
    check_val("rst_out_inst", out_inst, '0);
    check_val("rst_slot_valid", out_slot_valid, '0);

    @(posedge clock); #2 reset = 1'b1;
    @(negedge clock);
    check_val("boot_req", imem_req, 1'b1);
    check_val("boot_addr0", imem_addr, 11'h000);
    @(negedge clock);
    check_val("boot_addr1", imem_addr, 11'h008);
    check_val("boot_valid_early", out_valid, 1'b0);
    @(negedge clock);
    check_val("boot_addr2", imem_addr, 11'h010);
    check_val("boot_valid", out_valid, 1'b1);
    check_val("boot_pc", out_pc, 32'h0);
    check_val("boot_inst", out_inst, {32'h100, 32'h101});
    check_val("boot_mask", out_slot_valid, 2'b11);
    repeat (5) @(negedge clock);

    redirect_and_land(32'h1C);
    @(negedge clock);
    check_val("after_redir_pc", out_pc, block_of(32'h1C) + FB);
    check_val("after_redir_mask", out_slot_valid, model_mask(0));
    repeat (3) @(negedge clock);

    redirect_and_land(32'h7F8);
    repeat (3) @(negedge clock);
    redirect_and_land(32'h34);
    repeat (3) @(negedge clock);

    @(posedge clock); #2 out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_val("burst_valid", out_valid, 1'b1);
    @(posedge clock); #2 reset = 1'b0;
    #1;
    check_val("midrst_valid", out_valid, 1'b0);
    check_val("midrst_req", imem_req, 1'b0);
    check_val("midrst_mask", out_slot_valid, '0);
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    nreq     = 0;
    head_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (c == 0) check_val("restart_addr", imem_addr, block_of(RST_PC));
      if (imem_req) nreq++;
      if (out_valid && out_pc !== block_of(RST_PC)) head_bad++;
    end
    check_val("stall_req_count", nreq, DEPTH);
    check_val("stall_req_idle", imem_req, 1'b0);
    check_val("stall_head_pc", out_pc, block_of(RST_PC));
    check_val("stall_head_moved", head_bad, 0);
    acc0 = accepted;
    @(posedge clock); #2 out_ready = 1'b1;
    repeat (8) @(negedge clock);
    check_val("stall_drain", (accepted - acc0) >= DEPTH, 1'b1);

    acc0 = accepted;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock); #2;
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom_range(0, IMEM - 1);
    end
    @(posedge clock); #2;
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (10) @(negedge clock);
    check_val("random_progress", accepted > acc0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
